// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller and its BCD counter.
package stopwatch_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    CLEAR   = 2'd3
  } state_t;

endpackage

// File: rtl/stopwatch_ctrl_bcd_counter.sv
// Cascaded BCD digit chain: increments by one on inc, synchronous clear, registered all-9s flag.
module bcd_counter
  import stopwatch_pkg::*;
#(
  parameter int unsigned N_DIGITS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic                          inc,
  output logic [DIGIT_W*N_DIGITS-1:0]   count,
  output logic                          all9
);

  localparam int unsigned CNT_W = DIGIT_W * N_DIGITS;

  logic [CNT_W-1:0] nxt;
  logic             nxt_all9;
  logic             carry;

  // Ripple the +1 through the digits; a digit at 9 rolls to 0 and passes the carry on.
  always_comb begin
    nxt      = count;
    carry    = 1'b1;
    nxt_all9 = 1'b1;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (carry) begin
        if (count[i*DIGIT_W +: DIGIT_W] == BCD_MAX) begin
          nxt[i*DIGIT_W +: DIGIT_W] = '0;
        end else begin
          nxt[i*DIGIT_W +: DIGIT_W] = count[i*DIGIT_W +: DIGIT_W] + DIGIT_W'(1);
          carry = 1'b0;
        end
      end
      if (nxt[i*DIGIT_W +: DIGIT_W] != BCD_MAX) begin
        nxt_all9 = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
      all9  <= 1'b0;
    end else if (inc) begin
      count <= nxt;
      all9  <= nxt_all9;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: start/stop/clear FSM, tick prescaler, BCD elapsed count, overflow flag.
// Lap capture is built only when STOPWATCH_LAP_EN is defined; otherwise lap outputs are tied low.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned N_DIGITS = 4,
  parameter int unsigned TICK_DIV = 100,
  parameter bit          WRAP     = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          keyout,
  input  logic                          clr_key,
  input  logic                          lap_key,
  output state_t                        state,
  output logic [DIGIT_W*N_DIGITS-1:0]   count,
  output logic [DIGIT_W*N_DIGITS-1:0]   lap,
  output logic                          lap_valid,
  output logic                          ovf
);

  localparam int unsigned CNT_W = DIGIT_W * N_DIGITS;
  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] pre;
  logic             all9;
  logic             tick_c;
  logic             inc_c;
  logic             clr_c;

  assign tick_c = (state == RUNNING) && (pre == PRE_MAX);
  // Saturating build suppresses the increment once all digits read 9.
  assign inc_c  = tick_c && (WRAP || !all9);
  assign clr_c  = (state == CLEAR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (keyout) state <= RUNNING;
        RUNNING: if (keyout) state <= PAUSED;
        PAUSED: begin
          if (clr_key)     state <= CLEAR;
          else if (keyout) state <= RUNNING;
        end
        CLEAR:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Prescaler holds mid-period while paused so a resume finishes the partial tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre <= '0;
    end else begin
      case (state)
        RUNNING: pre <= tick_c ? '0 : pre + PRE_W'(1);
        PAUSED:  pre <= pre;
        default: pre <= '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (WRAP) begin
      ovf <= tick_c && all9;
    end else if (clr_c) begin
      ovf <= 1'b0;
    end else if (tick_c && all9) begin
      ovf <= 1'b1;
    end
  end

  bcd_counter #(
    .N_DIGITS(N_DIGITS)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_c),
    .inc   (inc_c),
    .count (count),
    .all9  (all9)
  );

`ifdef STOPWATCH_LAP_EN
  // Lap takes the registered count, i.e. the value before any same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      lap       <= '0;
      lap_valid <= 1'b0;
    end else begin
      lap_valid <= (state == RUNNING) && lap_key;
      if (clr_c) begin
        lap <= '0;
      end else if ((state == RUNNING) && lap_key) begin
        lap <= count;
      end
    end
  end
`else
  logic lap_key_unused;
  assign lap_key_unused = lap_key;
  assign lap            = CNT_W'(0);
  assign lap_valid      = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: wrapping and saturating instances share one stimulus stream.
module tb_stopwatch_ctrl;
  import stopwatch_pkg::*;

  localparam int unsigned ND = 2;
  localparam int unsigned TD = 4;
`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  typedef struct {
    logic [1:0] st;
    logic [7:0] c1, l1, c0, l0;
    logic       lv, o1, o0;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0, keyout = 1'b0, clr_key = 1'b0, lap_key = 1'b0;
  state_t     st1, st0;
  logic [7:0] cnt1, lap1, cnt0, lap0;
  logic       lv1, lv0, ov1, ov0;

  exp_t sb[$];
  int   total = 0;
  int   passes = 0;

  // Reference model: decimal elapsed value, phase within the tick period, abstract state number.
  int m_st = 0, m_ph = 0, m_v1 = 0, m_v0 = 0, m_l1 = 0, m_l0 = 0;
  bit m_o1 = 0, m_o0 = 0, m_lv = 0;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.N_DIGITS(ND), .TICK_DIV(TD), .WRAP(1'b1)) dut_wrap (
    .clk(clk), .rst(rst), .keyout(keyout), .clr_key(clr_key), .lap_key(lap_key),
    .state(st1), .count(cnt1), .lap(lap1), .lap_valid(lv1), .ovf(ov1)
  );

  stopwatch_ctrl #(.N_DIGITS(ND), .TICK_DIV(TD), .WRAP(1'b0)) dut_sat (
    .clk(clk), .rst(rst), .keyout(keyout), .clr_key(clr_key), .lap_key(lap_key),
    .state(st0), .count(cnt0), .lap(lap0), .lap_valid(lv0), .ovf(ov0)
  );

  function automatic logic [7:0] bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic bound_chk(input string name, input bit reached);
    total++;
    if (reached) passes++;
    else $display("FAIL %s: wait bound expired, got 0, expected 1", name);
  endtask

  task automatic model_step(input bit r, input bit k, input bit c, input bit l);
    bit   run, tick;
    exp_t e;
    if (r) begin
      m_st = 0; m_ph = 0; m_v1 = 0; m_v0 = 0; m_l1 = 0; m_l0 = 0;
      m_o1 = 0; m_o0 = 0; m_lv = 0;
    end else begin
      run  = (m_st == 1);
      tick = run && (m_ph == TD - 1);
      m_lv = LAP_EN && run && l;
      if (m_lv) begin
        m_l1 = m_v1; m_l0 = m_v0;
      end else if (m_st == 3) begin
        m_l1 = 0; m_l0 = 0;
      end
      m_o1 = tick && (m_v1 == 99);
      if (tick) begin
        m_v1 = (m_v1 + 1) % 100;
        if (m_v0 == 99) m_o0 = 1;
        else m_v0 = m_v0 + 1;
      end
      if (run) m_ph = (m_ph + 1) % TD;
      else if (m_st != 2) m_ph = 0;
      if (m_st == 3) begin
        m_v1 = 0; m_v0 = 0; m_o0 = 0;
      end
      case (m_st)
        0:       m_st = k ? 1 : 0;
        1:       m_st = k ? 2 : 1;
        2:       m_st = c ? 3 : (k ? 1 : 2);
        default: m_st = 0;
      endcase
    end
    e.st = 2'(m_st);
    e.c1 = bcd(m_v1); e.l1 = bcd(m_l1);
    e.c0 = bcd(m_v0); e.l0 = bcd(m_l0);
    e.lv = m_lv; e.o1 = m_o1; e.o0 = m_o0;
    sb.push_back(e);
  endtask

  task automatic step(input bit r, input bit k, input bit c, input bit l);
    rst = r; keyout = k; clr_key = c; lap_key = l;
    @(posedge clk);
    model_step(r, k, c, l);
    #1;
    rst = 1'b0; keyout = 1'b0; clr_key = 1'b0; lap_key = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: every post-edge output set is compared against the oldest queued expectation.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("state_wrap", 8'(st1),  8'(e.st));
      chk("state_sat",  8'(st0),  8'(e.st));
      chk("count_wrap", cnt1,     e.c1);
      chk("count_sat",  cnt0,     e.c0);
      chk("lap_wrap",   lap1,     e.l1);
      chk("lap_sat",    lap0,     e.l0);
      chk("lapv_wrap",  8'(lv1),  8'(e.lv));
      chk("lapv_sat",   8'(lv0),  8'(e.lv));
      chk("ovf_wrap",   8'(ov1),  8'(e.o1));
      chk("ovf_sat",    8'(ov0),  8'(e.o0));
    end
  end

  initial begin
    int n;
    // Reset and idle hold
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    // Start and run 40 cycles: ten ticks
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(40);
    // Pause exactly on a tick edge, then resume
    n = 0;
    while (m_ph != TD - 1 && n < 8) begin idle(1); n++; end
    bound_chk("wait_phase3", m_ph == TD - 1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(10);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(6);
    // Lap at 27, then lap request while paused
    n = 0;
    while (m_v1 != 27 && n < 200) begin idle(1); n++; end
    bound_chk("wait_count27", m_v1 == 27);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    idle(3);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);
    // keyout and clr_key together while paused: clear wins
    step(1'b0, 1'b1, 1'b1, 1'b0);
    idle(3);
    // Run through 99 to exercise wrap and saturation
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(410);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);
    // Reset with keyout mid-run at 15
    step(1'b0, 1'b1, 1'b0, 1'b0);
    n = 0;
    while (m_v1 != 15 && n < 100) begin idle(1); n++; end
    bound_chk("wait_count15", m_v1 == 15);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    idle(2);
    // Random key traffic
    for (int i = 0; i < 1200; i++) begin
      step($urandom_range(0, 299) == 0, $urandom_range(0, 24) == 0,
           $urandom_range(0, 9) == 0,  $urandom_range(0, 7) == 0);
    end
    repeat (2) @(negedge clk);
    total++;
    if (sb.size() == 0) passes++;
    else $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
